// File: rtl/i2c_bit_pkg.sv
// rtl/i2c_bit_pkg.sv - command codes, FSM states and line-drive decode for i2c_bit_ctrl
package i2c_bit_pkg;

  localparam int PHASE_W = 2;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_STOP  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  function automatic state_e cmd_state(input logic [1:0] cmd);
    state_e st;
    case (cmd)
      CMD_START: st = ST_START;
      CMD_STOP:  st = ST_STOP;
      CMD_WRITE: st = ST_WRITE;
      default:   st = ST_READ;
    endcase
    return st;
  endfunction

  // Returns {scl_low, sda_low}: which lines are pulled to 0 in a given state/phase.
  function automatic logic [1:0] line_drive(input state_e st, input logic [PHASE_W-1:0] ph,
                                            input logic wbit);
    logic [1:0] d;
    d = 2'b00;
    case (st)
      ST_START: d = {ph == 2'd3, ph[1]};
      ST_STOP:  d = {ph == 2'd0, ph != 2'd3};
      ST_WRITE: d = {(ph == 2'd0) || (ph == 2'd3), !wbit};
      ST_READ:  d = {(ph == 2'd0) || (ph == 2'd3), 1'b0};
      default:  d = 2'b00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - quarter bit-period tick generator with clear and freeze inputs
module i2c_qtick #(
  parameter int unsigned CLK_DIV = 32'd68
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic freeze_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = !clr_i && !freeze_i && (cnt_q == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (!freeze_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_bit_ctrl.sv
// rtl/i2c_bit_ctrl.sv - I2C bit-level controller driving open-drain SCL/SDA
// Optional SCL clock stretching: define CLOCK_STRETCH_EN.
module i2c_bit_ctrl
  import i2c_bit_pkg::*;
#(
  parameter int unsigned CLK_DIV = 32'd68
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic       bit_i,
  output logic       done_o,
  output logic       bit_o,
  output logic       arb_lost_o,
  inout  wire        scl_io,
  inout  wire        sda_io
);

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 wbit_q, wbit_d;
  logic                 done_q, done_d;
  logic                 arb_q, arb_d;
  logic                 rbit_q, rbit_d;
  logic                 ready_q, ready_d;
  logic                 scl_low_q, scl_low_d;
  logic                 sda_low_q, sda_low_d;
  logic [1:0]           scl_sync, sda_sync;
  logic                 scl_s, sda_s;
  logic                 tick, freeze, busy, accept, arb_hit;

  assign scl_io = scl_low_q ? 1'b0 : 1'bz;
  assign sda_io = sda_low_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= 2'b00;
      sda_sync <= 2'b00;
    end else begin
      scl_sync <= {scl_sync[0], scl_io};
      sda_sync <= {sda_sync[0], sda_io};
    end
  end

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
  assign busy  = (state_q != ST_IDLE);

`ifdef CLOCK_STRETCH_EN
  // Ignore SCL readback until the synchronizer has seen the line after our release.
  logic [1:0] rel_age_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rel_age_q <= 2'd0;
    end else if (scl_low_q) begin
      rel_age_q <= 2'd0;
    end else if (rel_age_q != 2'd2) begin
      rel_age_q <= rel_age_q + 2'd1;
    end
  end

  assign freeze = busy && !scl_low_q && (rel_age_q == 2'd2) && !scl_s;
`else
  logic unused_scl;
  assign unused_scl = scl_s;
  assign freeze     = 1'b0;
`endif

  i2c_qtick #(
    .CLK_DIV (CLK_DIV)
  ) u_qtick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (!busy),
    .freeze_i (freeze),
    .tick_o   (tick)
  );

  assign accept  = cmd_valid_i && ready_q;
  assign arb_hit = tick && !sda_s &&
                   (((state_q == ST_START) && (phase_q == 2'd1)) ||
                    ((state_q == ST_WRITE) && (phase_q == 2'd2) && wbit_q));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    wbit_d    = wbit_q;
    done_d    = 1'b0;
    arb_d     = arb_q;
    rbit_d    = rbit_q;
    scl_low_d = scl_low_q;
    sda_low_d = sda_low_q;

    if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d = cmd_state(cmd_i);
        phase_d = '0;
        wbit_d  = bit_i;
        arb_d   = 1'b0;
      end
    end else if (tick) begin
      if (state_q == ST_READ && phase_q == 2'd2) begin
        rbit_d = sda_s;
      end
      if (arb_hit) begin
        state_d = ST_IDLE;
        phase_d = '0;
        done_d  = 1'b1;
        arb_d   = 1'b1;
      end else if (&phase_q) begin
        state_d = ST_IDLE;
        phase_d = '0;
        done_d  = 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end

    // Normal completion keeps the last bus levels; arbitration loss lets go of the bus.
    if (state_d == ST_IDLE) begin
      if (arb_hit) begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
      end
    end else begin
      {scl_low_d, sda_low_d} = line_drive(state_d, phase_d, wbit_d);
    end

    ready_d = (state_d == ST_IDLE) && !done_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      wbit_q    <= 1'b0;
      done_q    <= 1'b0;
      arb_q     <= 1'b0;
      rbit_q    <= 1'b0;
      ready_q   <= 1'b0;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      wbit_q    <= wbit_d;
      done_q    <= done_d;
      arb_q     <= arb_d;
      rbit_q    <= rbit_d;
      ready_q   <= ready_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign done_o      = done_q;
  assign bit_o       = rbit_q;
  assign arb_lost_o  = arb_q;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// tb/tb_i2c_bit_ctrl.sv - scoreboard bench for i2c_bit_ctrl with CLK_DIV=4
module tb_i2c_bit_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic       bit_in = 1'b0;
  logic       ext_scl = 1'b0;
  logic       ext_sda = 1'b0;
  wire        cmd_ready, done, bit_out, arb_lost;
  wire        scl, sda;

  pullup (scl);
  pullup (sda);
  assign scl = ext_scl ? 1'b0 : 1'bz;
  assign sda = ext_sda ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_bit_ctrl #(
    .CLK_DIV (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_i       (cmd),
    .bit_i       (bit_in),
    .done_o      (done),
    .bit_o       (bit_out),
    .arb_lost_o  (arb_lost),
    .scl_io      (scl),
    .sda_io      (sda)
  );

  typedef struct {
    int   lat;
    int   tol;
    logic arb;
    logic chk_bit;
    logic bitv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_lat;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
      end else begin
        mon_e   = sb.pop_front();
        mon_lat = cyc - acc_cyc - 1;
        n_chk++;
        if (mon_lat < mon_e.lat - mon_e.tol || mon_lat > mon_e.lat + mon_e.tol) begin
          n_bad++;
          $display("FAIL latency: got %0d expected %0d +- %0d", mon_lat, mon_e.lat, mon_e.tol);
        end
        chk("arb_lost_at_done", arb_lost, mon_e.arb);
        if (mon_e.chk_bit) chk("bit_o_at_done", bit_out, mon_e.bitv);
        chk("ready_low_at_done", cmd_ready, 0);
      end
    end
  end

  // Returns at the negedge right after the accepting edge (cycle 0 of the command).
  task automatic issue(input logic [1:0] c, input logic b, input logic push, input int lat,
                       input int tol, input logic earb, input logic cb, input logic eb);
    int   n;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    bit_in    = b;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_chk++;
      n_bad++;
      $display("FAIL accept_timeout: got no ready expected ready");
    end else if (push) begin
      e.lat = lat; e.tol = tol; e.arb = earb; e.chk_bit = cb; e.bitv = eb;
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done");
      sb.delete();
    end
    @(negedge clk);
    chk("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_bit_o", bit_out, 0);
    chk("rst_arb", arb_lost, 0);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    // START: SDA falls with SCL high, then SCL falls
    issue(2'd0, 1'b0, 1'b1, 16, 0, 1'b0, 1'b0, 1'b0);
    wait_cyc(2);
    chk("start_p0_scl", scl, 1);
    chk("start_p0_sda", sda, 1);
    wait_cyc(8);
    chk("start_p2_scl", scl, 1);
    chk("start_p2_sda", sda, 0);
    wait_cyc(4);
    chk("start_p3_scl", scl, 0);
    chk("start_p3_sda", sda, 0);
    wait_idle();

    // WRITE 0
    issue(2'd2, 1'b0, 1'b1, 16, 0, 1'b0, 1'b0, 1'b0);
    wait_cyc(2);
    chk("wr0_p0_scl", scl, 0);
    wait_cyc(4);
    chk("wr0_p1_scl", scl, 1);
    chk("wr0_p1_sda", sda, 0);
    wait_idle();

    // READ with target driving 0, then with line released
    ext_sda = 1'b1;
    issue(2'd3, 1'b0, 1'b1, 16, 0, 1'b0, 1'b1, 1'b0);
    wait_cyc(6);
    chk("rd0_p1_scl", scl, 1);
    wait_idle();
    ext_sda = 1'b0;
    issue(2'd3, 1'b0, 1'b1, 16, 0, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // WRITE 1 uncontested
    issue(2'd2, 1'b1, 1'b1, 16, 0, 1'b0, 1'b0, 1'b0);
    wait_cyc(10);
    chk("wr1_p2_scl", scl, 1);
    chk("wr1_p2_sda", sda, 1);
    wait_idle();

    // STOP
    issue(2'd1, 1'b0, 1'b1, 16, 0, 1'b0, 1'b0, 1'b0);
    wait_cyc(6);
    chk("stop_p1_scl", scl, 1);
    chk("stop_p1_sda", sda, 0);
    wait_idle();
    chk("stop_scl_released", scl, 1);
    chk("stop_sda_released", sda, 1);

    // WRITE 1 against a target holding SDA low: lost at end of p2
    ext_sda = 1'b1;
    issue(2'd2, 1'b1, 1'b1, 12, 0, 1'b1, 1'b0, 1'b0);
    wait_idle();
    chk("arb_scl_released", scl, 1);
    ext_sda = 1'b0;
    #1;
    chk("arb_sda_released", sda, 1);
    chk("arb_held", arb_lost, 1);
    issue(2'd0, 1'b0, 1'b1, 16, 0, 1'b0, 1'b0, 1'b0);
    wait_cyc(1);
    chk("arb_cleared", arb_lost, 0);
    wait_idle();

    // Reset during WRITE p1 aborts silently
    issue(2'd2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    wait_cyc(5);
    chk("wr_pre_rst_sda", sda, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_scl", scl, 1);
    chk("rst_mid_sda", sda, 1);
    chk("rst_mid_ready", cmd_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst_mid", cmd_ready, 1);
    wait_cyc(20);

`ifdef CLOCK_STRETCH_EN
    // Target stretches SCL for 10 cycles during READ p1
    issue(2'd3, 1'b0, 1'b1, 26, 2, 1'b0, 1'b1, 1'b1);
    wait_cyc(3);
    ext_scl = 1'b1;
    wait_cyc(10);
    ext_scl = 1'b0;
    wait_idle();
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
